irq_ctrl: RTL and testbench

- Memory-mapped interrupt controller between the peripheral interrupt lines (timers, external generator) and the CP0 HWInt[5:0] input.
- Per-source edge/level capture, pending latch, mask and fixed priority.
- Claim/complete FSM lets the handler acknowledge one source at a time.
- Lower-or-equal-priority sources are blocked while one is in service.

---
 rtl/irq_ctrl_pkg.sv | 23 ++
 rtl/irq_prio_enc.sv | 28 ++
 rtl/irq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM
// encoding, CLAIM register field positions and the source-count limit.
package irq_ctrl_pkg;

    // CP0 HWInt is 6 bits wide, so no more than 6 sources can be wired up.
    localparam int N_SRC_MAX = 6;

    // Word offsets inside the block (byte address bits [3:2]).
    localparam logic [1:0] ADDR_PEND  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_MODE  = 2'd2;
    localparam logic [1:0] ADDR_CLAIM = 2'd3;

    // CLAIM register layout: {valid, zeros, id}.
    localparam int VALID_BIT = 31;
    localparam int ID_LSB    = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder, lowest set index wins.
// Ports:
//   vec - request vector
//   any - at least one bit of vec is set
//   id  - index of the lowest set bit (0 when vec is all zero)
module irq_prio_enc #(
    parameter int N    = 6,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    vec,
    output logic            any,
    output logic [ID_W-1:0] id
);

    // Scanning from the top down lets the lowest set index overwrite
    // any higher one, which gives lowest-index-first priority.
    always_comb begin
        any = 1'b0;
        id  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                any = 1'b1;
                id  = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller feeding CP0 HWInt[5:0].
// Captures edge or level requests per source, latches them as pending,
// masks them, and runs a claim/complete handshake that blocks requests
// of lower or equal priority while one source is in service.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   src        - raw interrupt lines, already synchronous to clk
//   addr       - register word offset (PEND, MASK, MODE, CLAIM)
//   we, wdata  - register write strobe and data
//   re         - register read strobe; a CLAIM read claims the top source
//   rdata      - combinational read data, zero when re is low
//   hwint      - registered interrupt vector, bits >= N_SRC tied to 0
//   in_service - high while a claimed source awaits completion
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no source claimed; every masked pending source may interrupt
// SERVICE | cur_id claimed; only sources with index below cur_id pass
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    input  logic             re,
    output logic [31:0]      rdata,
    output logic [5:0]       hwint,
    output logic             in_service
);

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] masked;
    logic [N_SRC-1:0] allow;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] claim_clr;
    logic [5:0]       hwint_d;

    state_t           state;
    state_t           state_d;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  cur_id_d;
    logic [ID_W-1:0]  top_id;
    logic             top_any;
    logic             claim_rd;
    logic             claim_wr;
    logic             claim_take;

    logic             unused_wdata;
    assign unused_wdata = ^wdata[31:N_SRC];

    assign claim_rd   = re && (addr == ADDR_CLAIM);
    assign claim_wr   = we && (addr == ADDR_CLAIM);
    assign in_service = (state == SERVICE);

    // top_id ignores the in-service blocking so a CLAIM read in IDLE
    // always reports the highest-priority unmasked source.
    assign masked = pending & mask;

    irq_prio_enc #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .vec (masked),
        .any (top_any),
        .id  (top_id)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cur_id <= '0;
        end else begin
            state  <= state_d;
            cur_id <= cur_id_d;
        end
    end

    always_comb begin
        state_d    = state;
        cur_id_d   = cur_id;
        claim_take = 1'b0;
        case (state)
            IDLE: begin
                if (claim_rd && top_any) begin
                    state_d    = SERVICE;
                    cur_id_d   = top_id;
                    claim_take = 1'b1;
                end
            end
            SERVICE: begin
                // Completion must name the claimed source; anything else is dropped.
                if (claim_wr && (wdata[ID_W-1:0] == cur_id)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- capture and pending ----------------
    always_comb begin
        rise      = src & ~src_q;
        w1c       = '0;
        claim_clr = '0;
        allow     = '0;
        if (we && (addr == ADDR_PEND)) begin
            w1c = wdata[N_SRC-1:0] & mode;
        end
        for (int i = 0; i < N_SRC; i++) begin
            claim_clr[i] = claim_take && mode[i] && (top_id == ID_W'(i));
            allow[i]     = (state == IDLE) || (ID_W'(i) < cur_id);
        end
        // Edge bits: a new rising edge beats a clear in the same cycle.
        // Level bits simply follow the line.
        pending_d = (mode & (rise | (pending & ~w1c & ~claim_clr)))
                  | (~mode & src);
        eligible  = masked & allow;
        hwint_d   = '0;
        hwint_d[N_SRC-1:0] = eligible;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q   <= '0;
            pending <= '0;
            mask    <= '0;
            mode    <= '0;
            hwint   <= '0;
        end else begin
            src_q   <= src;
            pending <= pending_d;
            hwint   <= hwint_d;
            if (we && (addr == ADDR_MASK)) begin
                mask <= wdata[N_SRC-1:0];
            end
            if (we && (addr == ADDR_MODE)) begin
                mode <= wdata[N_SRC-1:0];
            end
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        rdata = '0;
        if (re && !reset) begin
            case (addr)
                ADDR_PEND: rdata[N_SRC-1:0] = pending;
                ADDR_MASK: rdata[N_SRC-1:0] = mask;
                ADDR_MODE: rdata[N_SRC-1:0] = mode;
                ADDR_CLAIM: begin
                    if (state == SERVICE) begin
                        rdata[ID_LSB +: ID_W] = cur_id;
                    end else if (top_any) begin
                        rdata[VALID_BIT]      = 1'b1;
                        rdata[ID_LSB +: ID_W] = top_id;
                    end
                end
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Stimulus pushes hand-computed expectations
// into a queue; a monitor on the falling edge pops and compares them.
module tb_irq_ctrl;

    localparam int K_RDATA = 0;
    localparam int K_HWINT = 1;
    localparam int K_INSRV = 2;

    localparam logic [1:0] A_PEND  = 2'd0;
    localparam logic [1:0] A_MASK  = 2'd1;
    localparam logic [1:0] A_MODE  = 2'd2;
    localparam logic [1:0] A_CLAIM = 2'd3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic        clk;
    logic        reset;
    logic [5:0]  src;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] rdata;
    logic [5:0]  hwint;
    logic        in_service;

    chk_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    irq_ctrl #(.N_SRC(6), .ID_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .src        (src),
        .addr       (addr),
        .we         (we),
        .wdata      (wdata),
        .re         (re),
        .rdata      (rdata),
        .hwint      (hwint),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: everything queued since the last rising edge refers to the
    // DUT state visible now.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = exp_q.pop_front();
            case (c.kind)
                K_RDATA: act = rdata;
                K_HWINT: act = {26'd0, hwint};
                default: act = {31'd0, in_service};
            endcase
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        exp_q.push_back(c);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        addr = a;
        re   = 1'b1;
        expect_val(K_RDATA, exp, name);
        tick();
        re   = 1'b0;
    endtask

    task automatic pulse(input logic [5:0] v);
        src = v;
        tick();
        src = '0;
    endtask

    initial begin
        reset = 1'b1;
        src   = '0;
        addr  = '0;
        we    = 1'b0;
        wdata = '0;
        re    = 1'b0;
        tick();
        tick();
        expect_val(K_HWINT, 32'h0, "reset_hwint");
        expect_val(K_INSRV, 32'h0, "reset_in_service");
        rd(A_CLAIM, 32'h0, "reset_rdata");
        reset = 1'b0;
        tick();

        // Edge capture and latency.
        wr(A_MASK, 32'h3F);
        wr(A_MODE, 32'h3F);
        rd(A_MODE, 32'h3F, "mode_readback");
        pulse(6'h04);
        expect_val(K_HWINT, 32'h0, "hwint_latency_one");
        rd(A_PEND, 32'h04, "pend_after_pulse2");
        expect_val(K_HWINT, 32'h04, "hwint_latency_two");
        rd(A_CLAIM, 32'h8000_0002, "claim_id2");
        expect_val(K_INSRV, 32'h1, "in_service_after_claim");
        rd(A_PEND, 32'h0, "pend_cleared_by_claim");

        // Blocking while in service.
        pulse(6'h10);
        tick();
        expect_val(K_HWINT, 32'h0, "hwint_blocked_src4");
        pulse(6'h01);
        tick();
        expect_val(K_HWINT, 32'h01, "hwint_preempt_src0");
        wr(A_CLAIM, 32'h2);
        tick();
        expect_val(K_HWINT, 32'h11, "hwint_after_complete");
        expect_val(K_INSRV, 32'h0, "idle_after_complete");
        wr(A_PEND, 32'h3F);
        rd(A_PEND, 32'h0, "pend_w1c_all");

        // Level mode.
        wr(A_MODE, 32'h0);
        wr(A_MASK, 32'h02);
        src = 6'h02;
        tick();
        tick();
        expect_val(K_HWINT, 32'h02, "level_hwint");
        wr(A_PEND, 32'h02);
        expect_val(K_HWINT, 32'h02, "level_hwint_after_w1c");
        rd(A_PEND, 32'h02, "level_pend_after_w1c");
        src = '0;
        tick();
        expect_val(K_HWINT, 32'h02, "level_drop_hwint_lag");
        rd(A_PEND, 32'h0, "level_drop_pend");
        expect_val(K_HWINT, 32'h0, "level_drop_hwint");

        // Edge set wins over same-cycle W1C.
        wr(A_MODE, 32'h3F);
        wr(A_MASK, 32'h3F);
        src   = 6'h08;
        addr  = A_PEND;
        wdata = 32'h08;
        we    = 1'b1;
        tick();
        src   = '0;
        we    = 1'b0;
        rd(A_PEND, 32'h08, "set_beats_w1c");
        wr(A_PEND, 32'h08);
        rd(A_PEND, 32'h0, "w1c_bit3");

        // Mismatched completion, no nesting, reset out of SERVICE.
        pulse(6'h04);
        rd(A_CLAIM, 32'h8000_0002, "claim_id2_again");
        wr(A_CLAIM, 32'h5);
        expect_val(K_INSRV, 32'h1, "bad_complete_ignored");
        rd(A_CLAIM, 32'h0000_0002, "claim_read_in_service");
        expect_val(K_INSRV, 32'h1, "no_nesting");
        reset = 1'b1;
        tick();
        expect_val(K_INSRV, 32'h0, "reset_from_service");
        expect_val(K_HWINT, 32'h0, "reset_hwint_cleared");
        rd(A_CLAIM, 32'h0, "reset_rdata_zero");
        reset = 1'b0;
        tick();

        // All masked, then unmask only source 5.
        wr(A_MODE, 32'h3F);
        pulse(6'h3F);
        tick();
        rd(A_PEND, 32'h3F, "pend_all");
        expect_val(K_HWINT, 32'h0, "hwint_all_masked");
        rd(A_CLAIM, 32'h0, "claim_nothing");
        expect_val(K_INSRV, 32'h0, "idle_nothing_claimed");
        rd(A_MASK, 32'h0, "mask_after_reset");
        wr(A_MASK, 32'h20);
        rd(A_CLAIM, 32'h8000_0005, "claim_id5");
        expect_val(K_HWINT, 32'h20, "hwint_src5");
        expect_val(K_INSRV, 32'h1, "service_id5");
        rd(A_PEND, 32'h1F, "pend_after_claim5");
        expect_val(K_HWINT, 32'h0, "hwint_blocked_by5");
        wr(A_CLAIM, 32'h5);
        expect_val(K_INSRV, 32'h0, "complete_id5");

        tick();
        tick();
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
